memory_controller: RTL
======================

MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have one parameter: ADDR_WIDTH, default 32, width of all address ports.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 mc_request_in  in  1  one-cycle request pulse from load/store buffer.
REQ-005 mc_rw_signal_in  in  1  0 = load, 1 = store.
REQ-006 mc_address_in  in  ADDR_WIDTH  byte address of access.
REQ-007 mc_goal_in  in  3  bytes to access: 1, 2 or 4.
REQ-008 mc_data_in  in  32  store data; low goal bytes used.
REQ-009 mc_ready_out  out  1  one-cycle completion pulse to load/store buffer.
REQ-010 mc_data_out  out  32  zero-extended load data, valid with mc_ready_out.
REQ-011 if_request_in  in  1  level; instruction fetch request, held until if_ready_out.
REQ-012 if_address_in  in  ADDR_WIDTH  fetch address, stable while if_request_in high.
REQ-013 if_ready_out  out  1  one-cycle fetch completion pulse.
REQ-014 if_inst_out  out  32  fetched word, valid with if_ready_out.
REQ-015 rob_rollback_in  in  1  misprediction flush.
REQ-016 mem_din  in  8  RAM read byte; valid one cycle after its address.
REQ-017 mem_dout  out  8  RAM write byte.
REQ-018 mem_a  out  ADDR_WIDTH  RAM byte address.
REQ-019 mem_wr  out  1  1 = write, 0 = read.

Function
REQ-020 SHALL implement FSM states IDLE, LSB_READ, LSB_WRITE, IF_READ.
REQ-021 SHALL latch every mc_request_in pulse (rw, address, goal, data) into one pending slot, whatever the current state.
REQ-022 In IDLE, SHALL start the pending LSB request in preference to if_request_in; LSB starvation by IF is not allowed.
REQ-023 Goal values other than 1 and 2 SHALL be treated as 4.
REQ-024 Read of N bytes: cycles 1..N after start SHALL drive mem_a = base+k with k = 0..N-1, and mem_wr = 0.
REQ-025 Read bytes SHALL be assembled little-endian (byte k into bits 8k+7:8k), with unused upper bytes 0.
REQ-026 Read completion pulse SHALL be registered, asserted N+2 cycles after the start cycle, then FSM returns to IDLE.
REQ-027 Write of N bytes: cycles 1..N SHALL drive mem_wr = 1, mem_a = base+k, mem_dout = data byte k.
REQ-028 Write completion: mc_ready_out SHALL pulse in cycle N+1, with mc_data_out = 0.
REQ-029 IF_READ SHALL always read 4 bytes from if_address_in and pulse if_ready_out.
REQ-030 Outside active write cycles, mem_wr SHALL be 0 and mem_dout 0.
REQ-031 In IDLE, mem_a SHALL be 0.
REQ-032 Ready outputs SHALL never be high for more than one consecutive cycle per request.
REQ-033 Byte address increments SHALL wrap modulo 2^ADDR_WIDTH.
REQ-034 rob_rollback_in high SHALL abort LSB_READ or IF_READ with no ready pulse, and force IDLE next cycle.
REQ-035 rob_rollback_in high SHALL clear a pending load, and SHALL ignore mc_request_in and if_request_in in that cycle.
REQ-036 rob_rollback_in SHALL NOT abort LSB_WRITE or a pending store; a committed store completes with its ready pulse.

Reset
REQ-037 rst low SHALL immediately force IDLE and clear the pending slot and byte counter.
REQ-038 rst low SHALL immediately drive mc_ready_out, if_ready_out, mem_wr = 0 and mc_data_out, if_inst_out, mem_dout, mem_a = 0.
REQ-039 Reset mid-access SHALL drop the access silently, with no ready pulse after release.

Verification
REQ-040 Bench SHALL cover LW at 0x100 with RAM bytes 11,22,33,44 -> mem_a 0x100..0x103 in cycles 1-4, mc_ready_out in cycle 6, mc_data_out = 0x44332211.
REQ-041 Bench SHALL cover LB at 0x7 with byte 0x80 -> mc_data_out = 0x00000080, ready in cycle 3.
REQ-042 Bench SHALL cover SH of 0xDEADBEEF to 0x20 -> writes EF@0x20 then BE@0x21 in cycles 1-2, ready in cycle 3, RAM 0x22 untouched.
REQ-043 Bench SHALL cover an LSB pulse during an IF fetch of 0x0 -> IF completes first, LSB access starts from IDLE next.
REQ-044 Bench SHALL cover rollback in cycle 2 of an LW -> no mc_ready_out, IDLE next cycle, mem_wr stays 0.
REQ-045 Bench SHALL cover rollback in cycle 1 of SW 0x12345678 to 0x40 -> all 4 bytes written and mc_ready_out in cycle 5.

Source files
------------

// File: rtl/memory_controller.sv
// Memory controller: arbitrates between the load/store buffer (LSB) and instruction
// fetch (IF) for a byte-wide RAM with one-cycle read latency.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   mc_request_in             one-cycle LSB request pulse (latched into a pending slot)
//   mc_rw_signal_in           0 = load, 1 = store
//   mc_address_in, mc_goal_in byte address and size (1, 2, anything else = 4)
//   mc_data_in                store data, low bytes used
//   mc_ready_out, mc_data_out LSB completion pulse and zero-extended load data
//   if_request_in             level fetch request, held until if_ready_out
//   if_address_in             fetch address
//   if_ready_out, if_inst_out fetch completion pulse and fetched word
//   rob_rollback_in           flush: aborts reads and pending loads, never stores
//   mem_din, mem_dout         RAM read / write byte
//   mem_a, mem_wr             RAM byte address and write enable
module memory_controller #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mc_request_in,
    input  logic                  mc_rw_signal_in,
    input  logic [ADDR_WIDTH-1:0] mc_address_in,
    input  logic [2:0]            mc_goal_in,
    input  logic [31:0]           mc_data_in,
    output logic                  mc_ready_out,
    output logic [31:0]           mc_data_out,
    input  logic                  if_request_in,
    input  logic [ADDR_WIDTH-1:0] if_address_in,
    output logic                  if_ready_out,
    output logic [31:0]           if_inst_out,
    input  logic                  rob_rollback_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    typedef enum logic [1:0] {Idle, LsbRead, LsbWrite, IfRead} state_t;

    state_t                state;
    logic                  pend_valid;
    logic                  pend_rw;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [2:0]            pend_size;
    logic [31:0]           pend_data;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [2:0]            size;
    logic [31:0]           wr_data;
    logic [2:0]            cnt;
    logic [31:0]           rd_data;

    logic                  start_lsb;
    logic                  start_if;
    logic [2:0]            cnt_p1;
    logic [1:0]            rd_idx;
    logic [31:0]           rd_merge;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [7:0]            wr_byte_next;

    function automatic logic [2:0] goal_to_size(input logic [2:0] goal);
        if (goal == 3'd1) begin
            return 3'd1;
        end else if (goal == 3'd2) begin
            return 3'd2;
        end
        return 3'd4;
    endfunction

    always_comb begin
        start_lsb    = (state == Idle) && pend_valid && !rob_rollback_in;
        // if_ready_out high means the fetch unit has not yet dropped its request for
        // the word just delivered; starting again would fetch it twice.
        start_if     = (state == Idle) && !pend_valid && if_request_in && !if_ready_out &&
                       !rob_rollback_in;
        cnt_p1       = cnt + 3'd1;
        // cnt is one ahead of the byte on mem_din (one-cycle RAM latency); cnt == 4 wraps
        // to index 3 in two bits.
        rd_idx       = cnt[1:0] - 2'd1;
        rd_merge     = rd_data | (32'(mem_din) << {rd_idx, 3'b000});
        addr_next    = base_addr + ADDR_WIDTH'(cnt_p1);
        wr_byte_next = wr_data[{cnt_p1[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= Idle;
            pend_valid   <= 1'b0;
            pend_rw      <= 1'b0;
            pend_addr    <= '0;
            pend_size    <= 3'd0;
            pend_data    <= 32'h0;
            base_addr    <= '0;
            size         <= 3'd0;
            wr_data      <= 32'h0;
            cnt          <= 3'd0;
            rd_data      <= 32'h0;
            mc_ready_out <= 1'b0;
            mc_data_out  <= 32'h0;
            if_ready_out <= 1'b0;
            if_inst_out  <= 32'h0;
            mem_dout     <= 8'h00;
            mem_a        <= '0;
            mem_wr       <= 1'b0;
        end else begin
            mc_ready_out <= 1'b0;
            if_ready_out <= 1'b0;

            // Pending slot: a new pulse always wins, even in the cycle the old one starts.
            if (mc_request_in && !rob_rollback_in) begin
                pend_valid <= 1'b1;
                pend_rw    <= mc_rw_signal_in;
                pend_addr  <= mc_address_in;
                pend_size  <= goal_to_size(mc_goal_in);
                pend_data  <= mc_data_in;
            end else if (start_lsb) begin
                pend_valid <= 1'b0;
            end else if (rob_rollback_in && !pend_rw) begin
                pend_valid <= 1'b0;
            end

            case (state)
                Idle: begin
                    if (start_lsb) begin
                        state     <= pend_rw ? LsbWrite : LsbRead;
                        base_addr <= pend_addr;
                        size      <= pend_size;
                        wr_data   <= pend_data;
                        cnt       <= 3'd0;
                        rd_data   <= 32'h0;
                        mem_a     <= pend_addr;
                        mem_wr    <= pend_rw;
                        mem_dout  <= pend_rw ? pend_data[7:0] : 8'h00;
                    end else if (start_if) begin
                        state     <= IfRead;
                        base_addr <= if_address_in;
                        size      <= 3'd4;
                        cnt       <= 3'd0;
                        rd_data   <= 32'h0;
                        mem_a     <= if_address_in;
                    end
                end

                LsbRead, IfRead: begin
                    if (rob_rollback_in) begin
                        state <= Idle;
                        mem_a <= '0;
                        cnt   <= 3'd0;
                    end else begin
                        if (cnt != 3'd0) begin
                            rd_data <= rd_merge;
                        end
                        if (cnt == size) begin
                            state <= Idle;
                            mem_a <= '0;
                            cnt   <= 3'd0;
                            if (state == IfRead) begin
                                if_ready_out <= 1'b1;
                                if_inst_out  <= rd_merge;
                            end else begin
                                mc_ready_out <= 1'b1;
                                mc_data_out  <= rd_merge;
                            end
                        end else begin
                            mem_a <= (cnt_p1 < size) ? addr_next : '0;
                            cnt   <= cnt_p1;
                        end
                    end
                end

                LsbWrite: begin
                    // Stores are committed: rollback does not touch this state.
                    if (cnt_p1 < size) begin
                        mem_a    <= addr_next;
                        mem_dout <= wr_byte_next;
                        cnt      <= cnt_p1;
                    end else begin
                        state        <= Idle;
                        mem_a        <= '0;
                        mem_wr       <= 1'b0;
                        mem_dout     <= 8'h00;
                        cnt          <= 3'd0;
                        mc_ready_out <= 1'b1;
                        mc_data_out  <= 32'h0;
                    end
                end

                default: state <= Idle;
            endcase
        end
    end

endmodule
